div_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the integer divide unit in the MIPS execute stage.
- Accepts a DIV/DIVU request from the ALU decode path and runs a radix-2 restoring divide over 32 iterations.
- Drives busy to stall the pipeline while it runs.
- Delivers the registered Quotient (to LO) and Remainder (to HI) with N/Z flags and a one-cycle done pulse.

---
 rtl/div_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle radix-2 restoring divide sequencer for the MIPS execute stage.
//
// Runs DIV (signed) / DIVU (unsigned) in a fixed 34 edges from the accepting edge:
// IDLE -> PREP -> ITER (WIDTH edges) -> FIX -> IDLE.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE
//   op_signed  in   1 = DIV, 0 = DIVU (captured with start)
//   S_DIV      in   dividend (captured with start)
//   T_DIV      in   divisor (captured with start)
//   busy       out  operation in flight (pipeline stall)
//   done       out  one-cycle pulse when results update
//   Quotient   out  registered quotient (LO)
//   Remainder  out  registered remainder (HI)
//   N_DIV      out  sign bit of last quotient
//   Z_DIV      out  last quotient was zero
//   div_zero   out  last result came from a zero divisor
module div_seq_ctrl #(
    parameter int              WIDTH  = 32,
    parameter logic [WIDTH-1:0] DIV0_Q = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] S_DIV,
    input  logic [WIDTH-1:0] T_DIV,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             N_DIV,
    output logic             Z_DIV,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sq_q, sq_d, sr_q, sr_d, div0_q, div0_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
    logic             n_q, n_d, z_q, z_d, dz_q, dz_d, done_q, done_d;
    logic [WIDTH:0]   sh, trial;
    logic [WIDTH-1:0] q_fix, r_fix;

    // One extra bit on the shifted remainder so the trial subtract's borrow shows up as bit WIDTH.
    assign sh    = {rem_q, quo_q[WIDTH-1]};
    assign trial = sh - {1'b0, dvs_q};
    // A zero divisor discards the iteration result and returns the original dividend as remainder.
    assign q_fix = div0_q ? DIV0_Q : (sq_q ? -quo_q : quo_q);
    assign r_fix = div0_q ? a_q : (sr_q ? -rem_q : rem_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        div0_d  = div0_q;
        q_d     = q_q;
        r_d     = r_q;
        n_d     = n_q;
        z_d     = z_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d     = S_DIV;
                b_d     = T_DIV;
                sgn_d   = op_signed;
                state_d = PREP;
            end
            PREP: begin
                // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
                quo_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
                dvs_d   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
                sq_d    = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                sr_d    = sgn_q && a_q[WIDTH-1];
                div0_d  = (b_q == '0);
                rem_d   = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                rem_d   = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
                quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : ITER;
            end
            FIX: begin
                q_d     = q_fix;
                r_d     = r_fix;
                n_d     = q_fix[WIDTH-1];
                z_d     = (q_fix == '0);
                dz_d    = div0_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            div0_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            div0_q  <= div0_d;
            q_q     <= q_d;
            r_q     <= r_d;
            n_q     <= n_d;
            z_q     <= z_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Quotient  = q_q;
    assign Remainder = r_q;
    assign N_DIV     = n_q;
    assign Z_DIV     = z_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed vector table plus hand sequences for the divide sequencer.
module tb_div_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] S_DIV = '0;
    logic [31:0] T_DIV = '0;
    logic        busy, done, N_DIV, Z_DIV, div_zero;
    logic [31:0] Quotient, Remainder;

    int checks = 0;
    int errors = 0;

    div_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op_signed(op_signed),
        .S_DIV(S_DIV), .T_DIV(T_DIV), .busy(busy), .done(done),
        .Quotient(Quotient), .Remainder(Remainder), .N_DIV(N_DIV),
        .Z_DIV(Z_DIV), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [31:0] s, t, q, r;
        logic        n, z, dz;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [31:0] q, r, input logic n, z, dz);
        chk({tag, "_Q"}, Quotient, q);
        chk({tag, "_R"}, Remainder, r);
        chk({tag, "_N"}, N_DIV, n);
        chk({tag, "_Z"}, Z_DIV, z);
        chk({tag, "_DZ"}, div_zero, dz);
    endtask

    // Issues one request, scrambles the operand inputs while busy, and checks busy/latency/done shape.
    task automatic run_op(input logic sg, input logic [31:0] s, t);
        int lat;
        int bad;
        @(negedge clk);
        op_signed = sg; S_DIV = s; T_DIV = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0; S_DIV = ~s; T_DIV = ~t; op_signed = ~sg;
        lat = 0; bad = 0;
        while (!done && lat < 60) begin
            if (!busy) bad++;
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 34);
        chk("busy_run", bad, 0);
        chk("busy_end", busy, 1'b0);
    endtask

    initial begin
        int lat;
        int pulses;
        v[0]  = '{1'b1, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 1'b0, 1'b0};
        v[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        v[2]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0, 1'b0, 1'b0};
        v[3]  = '{1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1'b1};
        v[4]  = '{1'b1, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1'b1};
        v[5]  = '{1'b1, 32'h80000001, 32'd0,        32'hFFFFFFFF, 32'h80000001, 1'b1, 1'b0, 1'b1};
        v[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b1, 1'b0, 1'b0};
        v[7]  = '{1'b1, 32'd3,        32'd7,        32'd0,        32'd3,        1'b0, 1'b1, 1'b0};
        v[8]  = '{1'b0, 32'd100,      32'd10,       32'd10,       32'd0,        1'b0, 1'b0, 1'b0};
        v[9]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b1, 1'b0, 1'b0};
        v[10] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        v[11] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
        v[12] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b1, 1'b0};
        v[13] = '{1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b1, 1'b0, 1'b0};

        #1 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk_res("rst", 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(v[i].sg, v[i].s, v[i].t);
            chk_res($sformatf("vec%0d", i), v[i].q, v[i].r, v[i].n, v[i].z, v[i].dz);
            @(negedge clk);
            chk("done_pulse", done, 1'b0);
            chk("hold_Q", Quotient, v[i].q);
        end

        // 100/10 at E0, 50/5 at E10 ignored, then 77/7 reissued at E35 completing at E69.
        @(negedge clk);
        op_signed = 1'b0; S_DIV = 32'd100; T_DIV = 32'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        S_DIV = 32'd50; T_DIV = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 10;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("drop_latency", lat, 34);
        chk_res("drop", 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
        S_DIV = 32'd77; T_DIV = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reissue_busy", busy, 1'b1);
        chk("reissue_done_low", done, 1'b0);
        lat = 0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("reissue_latency", lat, 34);
        chk_res("reissue", 32'd11, 32'd0, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("no_extra_done", pulses, 0);

        // Asynchronous reset at E20 of an operation aborts with no done.
        @(negedge clk);
        op_signed = 1'b1; S_DIV = 32'd7; T_DIV = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk_res("abort", 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("abort_quiet", pulses, 0);
        run_op(1'b0, 32'd100, 32'd10);
        chk_res("post_rst", 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
